// File: rtl/mul_pkg.sv
// Shared definitions for the iterative tree multiplier: iteration count,
// FSM state encoding and the conditional two's-complement helper.
package mul_pkg;

  // Widest operand the helper function below can handle.
  localparam int MAX_W = 64;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of CALC iterations needed to retire all W multiplier bits.
  function automatic int calc_k(input int w, input int n);
    return w / n;
  endfunction

  // Two's-complement negate when neg is set, pass-through otherwise.
  // Callers zero-extend into and truncate out of the fixed width.
  function automatic logic [2*MAX_W-1:0] cond_negate(input logic [2*MAX_W-1:0] v,
                                                     input logic              neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mul_pp_tree.sv
// Combinational partial-product reducer: sums the N shifted copies of b_mag
// selected by the bits of slice, through a pairwise adder tree.
module mul_pp_tree #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic [W-1:0]   b_mag,
  input  logic [N-1:0]   slice,
  output logic [W+N-1:0] sum
);

  // Leaf count padded to a power of two; unused leaves are tied to zero.
  localparam int P = 1 << $clog2(N);

  // Heap-ordered tree: node 0 is the root, leaves start at index P-1.
  logic [W+N-1:0] node [2*P-1];

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < N) begin : g_used
      assign node[P-1+i] = slice[i] ? ({{N{1'b0}}, b_mag} << i) : '0;
    end else begin : g_pad
      assign node[P-1+i] = '0;
    end
  end

  // Each interior node adds its two children; W+N bits cannot overflow
  // because the full sum is at most b_mag * (2^N - 1).
  for (genvar j = 0; j < P-1; j++) begin : g_add
    assign node[j] = node[2*j+1] + node[2*j+2];
  end

  assign sum = node[0];

endmodule

// File: rtl/iter_tree_multiplier.sv
// Multi-cycle signed/unsigned multiplier. Operands are converted to
// magnitudes on capture, N multiplier bits are retired per CALC cycle through
// mul_pp_tree, and the sign is applied to the full 2*W-bit sum at the end.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid depend only on the FSM state, never on
// in_valid/out_ready, so there is no combinational path between the sides.
module iter_tree_multiplier
  import mul_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  localparam int K  = calc_k(W, N);
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int SW = $clog2(2*W);

  if (W % N != 0) begin : g_bad_n
    $error("iter_tree_multiplier: W must be a multiple of N");
  end
  if (W > MAX_W) begin : g_bad_w
    $error("iter_tree_multiplier: W exceeds MAX_W");
  end

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           neg_q, neg_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] product_q, product_d;

  logic [W-1:0]   a_mag, b_mag;
  logic           neg_in;
  logic [W+N-1:0] pp_sum;
  logic [2*W-1:0] pp_ext;
  logic [SW-1:0]  shamt;
  logic [2*W-1:0] acc_next;
  logic [2*W-1:0] acc_signed;
  logic           last;

  // Operand conditioning at capture time. The magnitude of -2^(W-1) wraps to
  // 2^(W-1), which is exactly right as an unsigned W-bit value.
  assign neg_in = signed_mode & (a[W-1] ^ b[W-1]);
  assign a_mag  = W'(cond_negate((2*MAX_W)'(a), signed_mode & a[W-1]));
  assign b_mag  = W'(cond_negate((2*MAX_W)'(b), signed_mode & b[W-1]));

  mul_pp_tree #(
    .W(W),
    .N(N)
  ) u_pp_tree (
    .b_mag(b_q),
    .slice(a_q[N-1:0]),
    .sum  (pp_sum)
  );

  // Place this iteration's partial sum at bit position count*N.
  assign pp_ext     = (2*W)'(pp_sum);
  assign shamt      = SW'(cnt_q) * SW'(N);
  assign acc_next   = acc_q + (pp_ext << shamt);
  assign acc_signed = (2*W)'(cond_negate((2*MAX_W)'(acc_next), neg_q));
  assign last       = (cnt_q == CW'(K-1));

  // Next-state logic for the IDLE -> CALC -> DONE sequence and the datapath.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = neg_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = acc_next;
        a_d   = a_q >> N;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          product_d = acc_signed;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_iter_tree_multiplier.sv
// Bench for iter_tree_multiplier: directed table and corner sequences on a
// W=8/N=4 instance, plus randomized sweeps on W=8/N=1, W=8/N=8 and W=32/N=4
// instances checked against a plain-arithmetic product model.
module tb_iter_tree_multiplier;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed DUT (W=8, N=4, K=2) ----------------
  logic        rst_n;
  logic        in_valid, in_ready, signed_mode;
  logic [7:0]  a, b;
  logic        out_valid, out_ready, busy;
  logic [15:0] product;
  logic [1:0]  dbg_state;

  iter_tree_multiplier #(.W(8), .N(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  // ---------------- driver tasks ----------------
  // Called #1 after an edge with the DUT idle; returns #1 after the accept edge.
  task automatic start_op(input logic sm, input logic [7:0] av, input logic [7:0] bv);
    check("accept_ready", in_ready, 1);
    signed_mode = sm;
    a           = av;
    b           = bv;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_seen", out_valid, 1);
  endtask

  // ---------------- randomized instances ----------------
  localparam int NOPS   = 1000;
  localparam int BUDGET = 40000;

  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int RW = (g == 2) ? 32 : 8;
    localparam int RN = (g == 0) ? 1 : ((g == 1) ? 8 : 4);

    logic            r_rst_n, r_in_valid, r_in_ready, r_sm;
    logic            r_out_valid, r_out_ready, r_busy;
    logic [RW-1:0]   r_a, r_b;
    logic [2*RW-1:0] r_prod;
    logic [1:0]      r_state;
    logic            r_done = 1'b0;
    logic [2*RW-1:0] exp_q [$];

    iter_tree_multiplier #(.W(RW), .N(RN)) u_dut (
      .clk        (clk),
      .rst_n      (r_rst_n),
      .in_valid   (r_in_valid),
      .in_ready   (r_in_ready),
      .signed_mode(r_sm),
      .a          (r_a),
      .b          (r_b),
      .out_valid  (r_out_valid),
      .out_ready  (r_out_ready),
      .product    (r_prod),
      .busy       (r_busy),
      .dbg_state  (r_state)
    );

    function automatic logic [RW-1:0] rnd_op();
      logic [RW-1:0] v;
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = {1'b1, {(RW-1){1'b0}}};
        2:       v = '1;
        3:       v = {1'b0, {(RW-1){1'b1}}};
        default: v = RW'($urandom);
      endcase
      return v;
    endfunction

    initial begin : run
      int                     acc_cnt;
      int                     cyc;
      logic [2*RW-1:0]        e;
      logic signed [2*RW-1:0] sa, sb;
      r_rst_n     = 1'b0;
      r_in_valid  = 1'b0;
      r_sm        = 1'b0;
      r_a         = '0;
      r_b         = '0;
      r_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      r_rst_n = 1'b1;
      acc_cnt = 0;
      cyc     = 0;
      while ((acc_cnt < NOPS || exp_q.size() != 0) && cyc < BUDGET) begin
        r_in_valid  = (acc_cnt < NOPS) && ($urandom_range(0, 3) != 0);
        r_out_ready = ($urandom_range(0, 3) != 0);
        r_sm        = 1'($urandom_range(0, 1));
        r_a         = rnd_op();
        r_b         = rnd_op();
        // Reference model: full-width product of the two operands.
        if (r_in_valid && r_in_ready) begin
          if (r_sm) begin
            sa = $signed({{RW{r_a[RW-1]}}, r_a});
            sb = $signed({{RW{r_b[RW-1]}}, r_b});
            e  = sa * sb;
          end else begin
            e = {{RW{1'b0}}, r_a} * {{RW{1'b0}}, r_b};
          end
          exp_q.push_back(e);
          acc_cnt++;
        end
        if (r_out_valid && r_out_ready) begin
          if (exp_q.size() == 0) begin
            check("rand_spurious_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rand_product", 64'(r_prod), 64'(e));
          end
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      r_in_valid = 1'b0;
      check("rand_ops_accepted", acc_cnt, NOPS);
      check("rand_queue_drained", exp_q.size(), 0);
      r_done = 1'b1;
    end
  end

  // ---------------- directed test sequence ----------------
  initial begin : main
    int lat;
    int w;
    logic [15:0] held;

    vecs[0]  = '{1'b1, 8'h03, 8'h05, 16'h000F};
    vecs[1]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    vecs[2]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[3]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[4]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[5]  = '{1'b1, 8'h07, 8'hFA, 16'hFFD6};
    vecs[6]  = '{1'b0, 8'h00, 8'hFF, 16'h0000};
    vecs[7]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[8]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[9]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[10] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
    vecs[11] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    out_ready   = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors with out_ready held high.
    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].sm, vecs[i].a, vecs[i].b);
      check("busy_calc", busy, 1);
      wait_done(lat);
      check("latency", lat, 2);
      check("table_product", product, vecs[i].exp);
      @(posedge clk);
      #1;
      check("out_valid_one_cycle", out_valid, 0);
      check("idle_after_out", in_ready, 1);
    end

    // Backpressure: DONE must hold and ignore new operands.
    out_ready = 1'b0;
    start_op(1'b0, 8'd12, 8'd11);
    wait_done(lat);
    check("bp_product", product, 16'h0084);
    held = product;
    for (int i = 0; i < 5; i++) begin
      in_valid    = 1'b1;
      signed_mode = 1'($urandom_range(0, 1));
      a           = 8'($urandom);
      b           = 8'($urandom);
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_product_stable", product, held);
      check("bp_busy", busy, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    start_op(1'b1, 8'hF6, 8'h09);
    wait_done(lat);
    check("bp_next_latency", lat, 2);
    check("bp_next_product", product, 16'hFFA6);
    @(posedge clk);
    #1;

    // Reset in the middle of CALC.
    start_op(1'b0, 8'd200, 8'd3);
    check("mid_busy", busy, 1);
    check("mid_state", dbg_state, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_no_output", out_valid, 0);
    start_op(1'b1, 8'h07, 8'hFA);
    wait_done(lat);
    check("post_rst_latency", lat, 2);
    check("post_rst_product", product, 16'hFFD6);
    @(posedge clk);
    #1;

    // Wait for the randomized sweeps, bounded.
    w = 0;
    while (!(g_rand[0].r_done && g_rand[1].r_done && g_rand[2].r_done) && w < 60000) begin
      @(posedge clk);
      w++;
    end
    check("rand_sweeps_finished",
          {61'b0, g_rand[2].r_done, g_rand[1].r_done, g_rand[0].r_done}, 64'h7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
